reg_cmd_sequencer: RTL and testbench
====================================

REG_CMD_SEQUENCER -- requirements
Module: reg_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the width of the load data path.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 4, giving the width of the repeat-count field.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  sequencer can accept a command.
REQ-007 cmd_op  input  3  opcode: 0 NOP, 1 CLR, 2 LOAD, 3 INC, 4 DEC, 5 SHR, 6 SHL, 7 reserved.
REQ-008 cmd_amt  input  CNT_WIDTH  repeat count minus one, for INC/DEC/SHR/SHL.
REQ-009 cmd_data  input  DATA_WIDTH  load value, for LOAD.
REQ-010 cmd_fill  input  1  serial fill bit, for SHR/SHL.
REQ-011 cl, ld, inc, dec, sr, sl  output  1 each  one-cycle control pulses to the downstream register.
REQ-012 in  output  DATA_WIDTH  load data to the register.
REQ-013 ir, il  output  1 each  shift-in bits to the register.
REQ-014 busy  output  1  a command is executing.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 err  output  1  one-cycle pulse coincident with done for a reserved opcode.

Function
REQ-017 The FSM SHALL have states IDLE, EXEC and DONE.
REQ-018 cmd_ready SHALL be 1 only in IDLE with rst deasserted.
REQ-019 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1; cmd_op, cmd_amt, cmd_data and cmd_fill SHALL be captured at that edge.
REQ-020 Acceptance at edge T SHALL move the FSM to EXEC in cycle T+1, or straight to DONE for NOP and reserved opcodes.
REQ-021 Pulse count N SHALL be 1 for CLR/LOAD, cmd_amt+1 for INC/DEC/SHR/SHL (1..2^CNT_WIDTH), and 0 for NOP/reserved.
REQ-022 In EXEC the block SHALL assert the selected pulse (CLR->cl, LOAD->ld, INC->inc, DEC->dec, SHR->sr, SHL->sl) in each of N consecutive cycles, then enter DONE.
REQ-023 At most one of cl/ld/inc/dec/sr/sl SHALL be 1 in any cycle, and all SHALL be 0 outside EXEC.
REQ-024 ir SHALL equal the captured fill whenever sr=1, and il SHALL equal it whenever sl=1; otherwise both SHALL be 0.
REQ-025 in SHALL hold the last captured cmd_data from the cycle after acceptance until the next acceptance.
REQ-026 DONE SHALL last exactly one cycle with done=1 (err=1 for reserved opcode), then return to IDLE.
REQ-027 busy SHALL be 1 in EXEC and DONE.
REQ-028 The internal repeat counter SHALL be CNT_WIDTH+1 bits wide so that cmd_amt all-ones produces 2^CNT_WIDTH pulses without wrap.
REQ-029 cmd_valid, and changes to the command inputs, SHALL be ignored while cmd_ready=0.
REQ-030 Back-to-back commands SHALL have a minimum spacing of N+2 cycles.

Reset
REQ-031 While rst=1 the FSM SHALL be IDLE, the counter 0, and in, captured fill, and every output 0, including cmd_ready.
REQ-032 rst asserted mid-command SHALL stop all pulses immediately (asynchronously), with no done pulse.
REQ-033 cmd_ready SHALL become 1 in the first cycle after rst deasserts.

Configuration
REQ-034 With REG_SEQ_ABORT_EN defined, the block SHALL add input abort (1 bit) and output aborted (1 bit).
REQ-035 With REG_SEQ_ABORT_EN defined, abort=1 sampled in EXEC SHALL force all pulses to 0 from the next cycle, return the FSM to IDLE, assert aborted for one cycle, and suppress done.
REQ-036 With REG_SEQ_ABORT_EN defined, abort SHALL be ignored in IDLE and DONE.
REQ-037 Without REG_SEQ_ABORT_EN, the abort and aborted ports SHALL not exist, and every accepted command SHALL run to completion unless reset.

Verification
REQ-038 LOAD, cmd_data=16'hA5C3, accepted at T -> ld=1 only in T+1, in=16'hA5C3 from T+1, done in T+2, cmd_ready in T+3.
REQ-039 SHR, amt=3, fill=1 -> sr=1 and ir=1 for cycles T+1..T+4, done in T+5, no other pulse asserted.
REQ-040 INC, amt=4'hF -> exactly 16 inc pulses, then one done; a reference register starting at 0 reads 16.
REQ-041 Reserved op 7, then NOP -> no control pulses; done+err in T+1; NOP gives done only.
REQ-042 DEC, amt=7, rst pulsed during the third pulse -> dec drops at once, no done, cmd_ready=1 the cycle after release.
REQ-043 With REG_SEQ_ABORT_EN, SHL amt=5, abort in second pulse cycle -> exactly 2 sl pulses, aborted=1, done never asserted.

Source files
------------

// File: rtl/reg_cmd_sequencer.sv
// Command sequencer that turns one accepted command into a burst of one-cycle control pulses for a downstream register.
// Optional abort support is enabled by defining REG_SEQ_ABORT_EN.
module reg_cmd_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [CNT_WIDTH-1:0]  cmd_amt,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic                  cmd_fill,
`ifdef REG_SEQ_ABORT_EN
  input  logic                  abort,
  output logic                  aborted,
`endif
  output logic                  cl,
  output logic                  ld,
  output logic                  inc,
  output logic                  dec,
  output logic                  sr,
  output logic                  sl,
  output logic [DATA_WIDTH-1:0] in,
  output logic                  ir,
  output logic                  il,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_CLR = 3'd1;
  localparam logic [2:0] OP_LD  = 3'd2;
  localparam logic [2:0] OP_INC = 3'd3;
  localparam logic [2:0] OP_DEC = 3'd4;
  localparam logic [2:0] OP_SHR = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;

  localparam logic [CNT_WIDTH:0] CNT_ONE = (CNT_WIDTH+1)'(1);

  state_t               state;
  logic [CNT_WIDTH:0]   cnt;
  logic [5:0]           pulse;
  logic                 fill_q;

  assign {sl, sr, dec, inc, ld, cl} = pulse;
  assign ir        = sr & fill_q;
  assign il        = sl & fill_q;
  assign busy      = (state != IDLE);
  assign cmd_ready = (state == IDLE) & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pulse   <= '0;
      fill_q  <= 1'b0;
      in      <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
`ifdef REG_SEQ_ABORT_EN
      aborted <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
`ifdef REG_SEQ_ABORT_EN
      aborted <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            in     <= cmd_data;
            fill_q <= cmd_fill;
            // Repeat count is widened by one bit so amt all-ones yields 2^CNT_WIDTH pulses.
            cnt    <= {1'b0, cmd_amt} + CNT_ONE;
            state  <= EXEC;
            case (cmd_op)
              OP_CLR: begin pulse <= 6'b000001; cnt <= CNT_ONE; end
              OP_LD:  begin pulse <= 6'b000010; cnt <= CNT_ONE; end
              OP_INC: pulse <= 6'b000100;
              OP_DEC: pulse <= 6'b001000;
              OP_SHR: pulse <= 6'b010000;
              OP_SHL: pulse <= 6'b100000;
              default: begin
                pulse <= '0;
                cnt   <= '0;
                state <= DONE;
                done  <= 1'b1;
                err   <= (cmd_op != OP_NOP);
              end
            endcase
          end
        end
        EXEC: begin
`ifdef REG_SEQ_ABORT_EN
          if (abort) begin
            pulse   <= '0;
            cnt     <= '0;
            state   <= IDLE;
            aborted <= 1'b1;
          end else
`endif
          if (cnt == CNT_ONE) begin
            pulse <= '0;
            cnt   <= '0;
            state <= DONE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        DONE: state <= IDLE;
        default: begin
          pulse <= '0;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// Directed self-checking bench for reg_cmd_sequencer; define REG_SEQ_ABORT_EN to also exercise abort.
module tb_reg_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_amt;
  logic [15:0] cmd_data;
  logic        cmd_fill;
  logic        cl, ld, inc, dec, sr, sl, ir, il, busy, done, err;
  logic [15:0] in;
`ifdef REG_SEQ_ABORT_EN
  logic        abort;
  logic        aborted;
`endif

  always #5 clk = ~clk;

  reg_cmd_sequencer #(.DATA_WIDTH(16), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_data(cmd_data), .cmd_fill(cmd_fill),
`ifdef REG_SEQ_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .cl(cl), .ld(ld), .inc(inc), .dec(dec), .sr(sr), .sl(sl),
    .in(in), .ir(ir), .il(il), .busy(busy), .done(done), .err(err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Observation record filled by capture (pulse index: 0 cl,1 ld,2 inc,3 dec,4 sr,5 sl)
  int pc[6];
  int first_c[6];
  int last_c[6];
  int multi, shin_bad, in_bad, busy_cnt;
  int done_cnt, done_cyc, err_cnt, err_cyc, ready_cyc, abt_cnt, abt_cyc;
  logic [15:0] exp_in;
  logic        exp_fill;
  logic [15:0] ref_reg;

  task automatic issue(input logic [2:0] op, input logic [3:0] amt,
                       input logic [15:0] data, input logic fill, input logic hold);
    cmd_op    = op;
    cmd_amt   = amt;
    cmd_data  = data;
    cmd_fill  = fill;
    cmd_valid = 1'b1;
    n_checks++;
    if (cmd_ready !== 1'b1)
      $display("FAIL ready_at_issue op=%0d: got %b want 1", op, cmd_ready);
    else
      n_pass++;
    @(posedge clk);
    #1;
    exp_in    = data;
    exp_fill  = fill;
    cmd_valid = hold;
    cmd_op    = 3'd1;
    cmd_amt   = 4'hF;
    cmd_data  = 16'hFFFF;
    cmd_fill  = ~fill;
  endtask

  task automatic capture(input int ncyc, input int drop_at, input int abort_at);
    logic [5:0] pv;
    for (int i = 0; i < 6; i++) begin pc[i] = 0; first_c[i] = 0; last_c[i] = 0; end
    multi = 0; shin_bad = 0; in_bad = 0; busy_cnt = 0;
    done_cnt = 0; done_cyc = 0; err_cnt = 0; err_cyc = 0; ready_cyc = 0;
    abt_cnt = 0; abt_cyc = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      pv = {sl, sr, dec, inc, ld, cl};
      for (int i = 0; i < 6; i++) if (pv[i]) begin
        pc[i]++;
        if (first_c[i] == 0) first_c[i] = c;
        last_c[i] = c;
      end
      if ($countones(pv) > 1) multi++;
      if (ir !== (sr & exp_fill) || il !== (sl & exp_fill)) shin_bad++;
      if (in !== exp_in) in_bad++;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; if (done_cyc == 0) done_cyc = c; end
      if (err) begin err_cnt++; if (err_cyc == 0) err_cyc = c; end
      if (cmd_ready && ready_cyc == 0) ready_cyc = c;
      if (cl) ref_reg = 16'h0;
      else if (ld) ref_reg = in;
      else if (inc) ref_reg = ref_reg + 16'd1;
      else if (dec) ref_reg = ref_reg - 16'd1;
      else if (sr) ref_reg = {ir, ref_reg[15:1]};
      else if (sl) ref_reg = {ref_reg[14:0], il};
`ifdef REG_SEQ_ABORT_EN
      if (aborted) begin abt_cnt++; if (abt_cyc == 0) abt_cyc = c; end
      abort = (c == abort_at);
`else
      if (abort_at < 0) abt_cnt = abt_cnt + 0;
`endif
      if (c == drop_at) cmd_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 3'd2; cmd_amt = 4'h3; cmd_data = 16'h1234; cmd_fill = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cmd_ready, busy, done, err, cl, ld, inc, dec, sr, sl, ir, il} !== 12'h000 || in !== 16'h0)
      $display("FAIL reset_outputs: ready=%b busy=%b done=%b pulses=%b in=%h want all 0",
               cmd_ready, busy, done, {cl, ld, inc, dec, sr, sl}, in);
    else n_pass++;
    cmd_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL ready_after_reset: ready=%b busy=%b want 1 0", cmd_ready, busy);
    else n_pass++;
  endtask

  task automatic test_load;
    issue(3'd2, 4'h0, 16'hA5C3, 1'b0, 1'b1);
    capture(3, 2, 0);
    n_checks++;
    if (pc[1] !== 1 || first_c[1] !== 1 || pc[0]+pc[2]+pc[3]+pc[4]+pc[5] !== 0)
      $display("FAIL load_pulse: ld_cnt=%0d first=%0d others=%0d want 1 1 0",
               pc[1], first_c[1], pc[0]+pc[2]+pc[3]+pc[4]+pc[5]);
    else n_pass++;
    n_checks++;
    if (in_bad !== 0) $display("FAIL load_in_hold: bad cycles %0d want 0 (in=%h)", in_bad, in);
    else n_pass++;
    n_checks++;
    if (done_cyc !== 2 || done_cnt !== 1 || err_cnt !== 0 || ready_cyc !== 3 || busy_cnt !== 2)
      $display("FAIL load_timing: done_cyc=%0d done_cnt=%0d err=%0d ready_cyc=%0d busy=%0d want 2 1 0 3 2",
               done_cyc, done_cnt, err_cnt, ready_cyc, busy_cnt);
    else n_pass++;
  endtask

  task automatic test_shr;
    issue(3'd5, 4'h3, 16'h0F0F, 1'b1, 1'b0);
    capture(6, 0, 0);
    n_checks++;
    if (pc[4] !== 4 || first_c[4] !== 1 || last_c[4] !== 4 || pc[0]+pc[1]+pc[2]+pc[3]+pc[5] !== 0)
      $display("FAIL shr_pulses: sr_cnt=%0d first=%0d last=%0d others=%0d want 4 1 4 0",
               pc[4], first_c[4], last_c[4], pc[0]+pc[1]+pc[2]+pc[3]+pc[5]);
    else n_pass++;
    n_checks++;
    if (shin_bad !== 0 || multi !== 0)
      $display("FAIL shr_fill: shin_bad=%0d multi=%0d want 0 0", shin_bad, multi);
    else n_pass++;
    n_checks++;
    if (done_cyc !== 5 || done_cnt !== 1 || ready_cyc !== 6)
      $display("FAIL shr_done: done_cyc=%0d done_cnt=%0d ready_cyc=%0d want 5 1 6", done_cyc, done_cnt, ready_cyc);
    else n_pass++;
  endtask

  task automatic test_inc_full;
    ref_reg = 16'h0;
    issue(3'd3, 4'hF, 16'h0000, 1'b0, 1'b0);
    capture(18, 0, 0);
    n_checks++;
    if (pc[2] !== 16 || last_c[2] !== 16 || done_cnt !== 1 || done_cyc !== 17)
      $display("FAIL inc_full: inc_cnt=%0d last=%0d done_cnt=%0d done_cyc=%0d want 16 16 1 17",
               pc[2], last_c[2], done_cnt, done_cyc);
    else n_pass++;
    n_checks++;
    if (ref_reg !== 16'd16) $display("FAIL inc_ref: ref=%0d want 16", ref_reg);
    else n_pass++;
  endtask

  task automatic test_reserved_nop;
    issue(3'd7, 4'h5, 16'h1111, 1'b1, 1'b0);
    capture(2, 0, 0);
    n_checks++;
    if (pc[0]+pc[1]+pc[2]+pc[3]+pc[4]+pc[5] !== 0 || done_cyc !== 1 || err_cyc !== 1 || err_cnt !== 1 || ready_cyc !== 2)
      $display("FAIL reserved_op: pulses=%0d done_cyc=%0d err_cyc=%0d err_cnt=%0d ready=%0d want 0 1 1 1 2",
               pc[0]+pc[1]+pc[2]+pc[3]+pc[4]+pc[5], done_cyc, err_cyc, err_cnt, ready_cyc);
    else n_pass++;
    issue(3'd0, 4'h5, 16'h2222, 1'b1, 1'b0);
    capture(2, 0, 0);
    n_checks++;
    if (pc[0]+pc[1]+pc[2]+pc[3]+pc[4]+pc[5] !== 0 || done_cyc !== 1 || err_cnt !== 0)
      $display("FAIL nop_op: pulses=%0d done_cyc=%0d err_cnt=%0d want 0 1 0",
               pc[0]+pc[1]+pc[2]+pc[3]+pc[4]+pc[5], done_cyc, err_cnt);
    else n_pass++;
  endtask

  task automatic test_rst_mid;
    issue(3'd4, 4'h7, 16'h3333, 1'b0, 1'b0);
    capture(3, 0, 0);
    n_checks++;
    if (pc[3] !== 3 || dec !== 1'b1) $display("FAIL dec_before_rst: dec_cnt=%0d dec=%b want 3 1", pc[3], dec);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (dec !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0 || done !== 1'b0)
      $display("FAIL rst_async: dec=%b busy=%b ready=%b done=%b want 0 0 0 0", dec, busy, cmd_ready, done);
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    capture(3, 0, 0);
    n_checks++;
    if (done_cnt !== 0 || ready_cyc !== 1 || pc[3] !== 0)
      $display("FAIL rst_release: done_cnt=%0d ready_cyc=%0d dec_cnt=%0d want 0 1 0", done_cnt, ready_cyc, pc[3]);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    ref_reg = 16'hBEEF;
    issue(3'd1, 4'h0, 16'h00AA, 1'b0, 1'b0);
    capture(3, 0, 0);
    n_checks++;
    if (pc[0] !== 1 || done_cyc !== 2 || ready_cyc !== 3)
      $display("FAIL b2b_clr: cl_cnt=%0d done_cyc=%0d ready_cyc=%0d want 1 2 3", pc[0], done_cyc, ready_cyc);
    else n_pass++;
    issue(3'd6, 4'h1, 16'h00BB, 1'b0, 1'b0);
    capture(4, 0, 0);
    n_checks++;
    if (pc[5] !== 2 || first_c[5] !== 1 || shin_bad !== 0 || done_cyc !== 3 || ready_cyc !== 4)
      $display("FAIL b2b_shl: sl_cnt=%0d first=%0d shin_bad=%0d done_cyc=%0d ready=%0d want 2 1 0 3 4",
               pc[5], first_c[5], shin_bad, done_cyc, ready_cyc);
    else n_pass++;
    issue(3'd3, 4'h2, 16'h00CC, 1'b1, 1'b0);
    capture(5, 0, 0);
    n_checks++;
    if (ref_reg !== 16'd3 || il !== 1'b0 || ir !== 1'b0)
      $display("FAIL b2b_ref: ref=%h ir=%b il=%b want 0003 0 0", ref_reg, ir, il);
    else n_pass++;
  endtask

`ifdef REG_SEQ_ABORT_EN
  task automatic test_abort;
    issue(3'd6, 4'h5, 16'h4444, 1'b1, 1'b0);
    capture(6, 0, 2);
    n_checks++;
    if (pc[5] !== 2 || last_c[5] !== 2 || shin_bad !== 0)
      $display("FAIL abort_pulses: sl_cnt=%0d last=%0d shin_bad=%0d want 2 2 0", pc[5], last_c[5], shin_bad);
    else n_pass++;
    n_checks++;
    if (abt_cnt !== 1 || abt_cyc !== 3 || done_cnt !== 0 || ready_cyc !== 3)
      $display("FAIL abort_status: aborted_cnt=%0d cyc=%0d done_cnt=%0d ready=%0d want 1 3 0 3",
               abt_cnt, abt_cyc, done_cnt, ready_cyc);
    else n_pass++;
    abort = 1'b1;
    issue(3'd2, 4'h0, 16'h5555, 1'b0, 1'b0);
    capture(3, 0, 0);
    n_checks++;
    if (pc[1] !== 1 || abt_cnt !== 0 || done_cyc !== 2)
      $display("FAIL abort_ignored: ld_cnt=%0d aborted_cnt=%0d done_cyc=%0d want 1 0 2", pc[1], abt_cnt, done_cyc);
    else n_pass++;
  endtask
`endif

  initial begin
    cmd_valid = 1'b0;
    cmd_op = 3'd0; cmd_amt = 4'h0; cmd_data = 16'h0; cmd_fill = 1'b0;
    exp_in = 16'h0; exp_fill = 1'b0; ref_reg = 16'h0;
`ifdef REG_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_load();
    test_shr();
    test_inc_full();
    test_reserved_nop();
    test_rst_mid();
    test_back_to_back();
`ifdef REG_SEQ_ABORT_EN
    test_abort();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
